alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer around an external Hack-style combinational ALU.
// Runs single ALU ops, shift-add multiplies and repeated-doubling left shifts.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [5:0]  ctrl,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctrl,
  input  logic [15:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zr,
  output logic        ng,
  output logic        err
);

  localparam logic [5:0] CTRL_ZERO = 6'b101010;
  localparam logic [5:0] CTRL_ADD  = 6'b000010;
  localparam logic [5:0] CTRL_X    = 6'b001100;

  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_SHL    = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_SHL, S_DONE} state_e;

  state_e      state, state_next;
  logic [15:0] acc, acc_next;      // SINGLE: A, MUL: accumulator, SHL: shifted value
  logic [15:0] m, m_next;          // SINGLE: B, MUL: doubling multiplicand
  logic [15:0] q, q_next;          // MUL: multiplier, SHL: remaining shift count
  logic [4:0]  count, count_next;  // MUL cycle index; bit 0 selects the phase
  logic [5:0]  ctrl_q, ctrl_next;
  logic        load;
  logic [15:0] res_next;
  logic        err_next;

  always_ff @(posedge clk) begin
    // NOTE: every state and datapath register is cleared here, so no stale operand
    // or accumulator can leak into an operation started after an aborted one.
    if (!reset_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      m      <= '0;
      q      <= '0;
      count  <= '0;
      ctrl_q <= '0;
      result <= '0;
      zr     <= 1'b1;
      ng     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      m      <= m_next;
      q      <= q_next;
      count  <= count_next;
      ctrl_q <= ctrl_next;
      if (load) begin
        result <= res_next;
        zr     <= (res_next == 16'd0);
        ng     <= res_next[15];
        err    <= err_next;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    acc_next   = acc;
    m_next     = m;
    q_next     = q;
    count_next = count;
    ctrl_next  = ctrl_q;
    load       = 1'b0;
    res_next   = result;
    err_next   = 1'b0;
    alu_x      = '0;
    alu_y      = '0;
    alu_ctrl   = CTRL_ZERO;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_SINGLE: begin
              acc_next   = a;
              m_next     = b;
              ctrl_next  = ctrl;
              state_next = S_EXEC;
            end
            OP_MUL: begin
              acc_next   = '0;
              m_next     = a;
              q_next     = b;
              count_next = '0;
              state_next = S_MUL;
            end
            OP_SHL: begin
              acc_next   = a;
              q_next     = {12'd0, b[3:0]};
              state_next = S_SHL;
            end
            default: begin
              load       = 1'b1;
              res_next   = '0;
              err_next   = 1'b1;
              state_next = S_DONE;
            end
          endcase
        end
      end

      S_EXEC: begin
        alu_x      = acc;
        alu_y      = m;
        alu_ctrl   = ctrl_q;
        load       = 1'b1;
        res_next   = alu_out;
        state_next = S_DONE;
      end

      S_MUL: begin
        count_next = count + 5'd1;
        if (!count[0]) begin
          // Conditional add: pass acc through unchanged when the multiplier bit is 0.
          alu_x    = acc;
          alu_y    = m;
          alu_ctrl = q[0] ? CTRL_ADD : CTRL_X;
          acc_next = alu_out;
        end else begin
          alu_x    = m;
          alu_y    = m;
          alu_ctrl = CTRL_ADD;
          m_next   = alu_out;
          q_next   = q >> 1;
          if (count == 5'd31) begin
            load       = 1'b1;
            res_next   = acc;
            state_next = S_DONE;
          end
        end
      end

      S_SHL: begin
        alu_x = acc;
        alu_y = acc;
        if (q == 16'd0) begin
          alu_ctrl   = CTRL_X;
          load       = 1'b1;
          res_next   = alu_out;
          state_next = S_DONE;
        end else begin
          alu_ctrl = CTRL_ADD;
          acc_next = alu_out;
          q_next   = q - 16'd1;
          if (q == 16'd1) begin
            load       = 1'b1;
            res_next   = alu_out;
            state_next = S_DONE;
          end
        end
      end

      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: models the external ALU and scoreboards
// each request's result, flags and latency.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic [5:0]  ctrl;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctrl;
  logic        busy, done, zr, ng, err;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .ctrl(ctrl),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .busy(busy), .done(done), .result(result), .zr(zr), .ng(ng), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                           input logic [5:0] c);
    logic [15:0] x, y, o;
    x = c[5] ? 16'd0 : x_in;
    x = c[4] ? ~x : x;
    y = c[3] ? 16'd0 : y_in;
    y = c[2] ? ~y : y;
    o = c[1] ? (x + y) : (x & y);
    return c[0] ? ~o : o;
  endfunction

  always_comb alu_out = hack_alu(alu_x, alu_y, alu_ctrl);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation, present one request, then scramble the inputs while busy.
  task automatic launch(input string tag, input logic [1:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [5:0] cv,
                        input logic [15:0] er, input logic ee, input int lat);
    exp_t e;
    e.tag = tag; e.res = er; e.err = ee; e.lat = lat;
    sb.push_back(e);
    op = o; a = av; b = bv; ctrl = cv; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ctrl = 6'($urandom); op = 2'($urandom);
  endtask

  // Wait (bounded) for done, then pop and compare; leaves the bench in the DONE cycle.
  task automatic finish_op(input int cyc0);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    e = sb.pop_front();
    check({e.tag, "_latency"}, cyc, e.lat);
    check({e.tag, "_result"}, result, e.res);
    check({e.tag, "_zr"}, zr, (e.res == 16'd0));
    check({e.tag, "_ng"}, ng, e.res[15]);
    check({e.tag, "_err"}, err, e.err);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [5:0] cv,
                        input logic [15:0] er, input logic ee, input int lat);
    launch(tag, o, av, bv, cv, er, ee, lat);
    finish_op(1);
    step();
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_ctrl"}, alu_ctrl, 6'b101010);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          n, cyc;
    logic        saw_done;

    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; ctrl = '0;
    step(); step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_zr", zr, 1'b1);
    check("rst_ng", ng, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_alu_ctrl", alu_ctrl, 6'b101010);
    check("rst_alu_x", alu_x, 16'h0000);
    reset_n = 1'b1;
    step();

    run_op("single_add", 2'b00, 16'd5, 16'd3, 6'b000010, 16'h0008, 1'b0, 2);
    run_op("single_sub", 2'b00, 16'd3, 16'd5, 6'b010011, 16'hFFFE, 1'b0, 2);
    run_op("mul_300x7", 2'b01, 16'd300, 16'd7, 6'd0, 16'h0834, 1'b0, 33);
    run_op("mul_1234x10", 2'b01, 16'h1234, 16'h0010, 6'd0, 16'h2340, 1'b0, 33);
    run_op("mul_by0", 2'b01, 16'hBEEF, 16'h0000, 6'd0, 16'h0000, 1'b0, 33);
    run_op("shl_1x15", 2'b10, 16'h0001, 16'd15, 6'd0, 16'h8000, 1'b0, 16);
    run_op("shl_n0", 2'b10, 16'hABCD, 16'h0000, 6'd0, 16'hABCD, 1'b0, 2);
    run_op("reserved", 2'b11, 16'h1111, 16'h2222, 6'd0, 16'h0000, 1'b1, 1);
    run_op("single_clr_err", 2'b00, 16'd1, 16'd2, 6'b000010, 16'h0003, 1'b0, 2);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run_op("mul_rand", 2'b01, ra, rb, 6'd0, 16'(ra * rb), 1'b0, 33);
      n = int'(rb[3:0]);
      run_op("shl_rand", 2'b10, ra, rb, 6'd0, 16'(ra << n), 1'b0, ((n > 1) ? n : 1) + 1);
    end

    // Start pulses during MUL and in the DONE cycle must be ignored.
    launch("mul_ignore", 2'b01, 16'd300, 16'd7, 6'd0, 16'h0834, 1'b0, 33);
    cyc = 1;
    repeat (5) begin step(); cyc++; end
    op = 2'b00; a = 16'd9; b = 16'd9; ctrl = 6'b000010; start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    check("mul_ignore_busy", busy, 1'b1);
    finish_op(cyc);
    op = 2'b00; a = 16'd7; b = 16'd7; ctrl = 6'b000010; start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_busy", busy, 1'b0);
    check("done_start_done", done, 1'b0);
    check("done_start_result", result, 16'h0834);
    step();
    check("done_start_still_idle", busy, 1'b0);

    // Reset at MUL cycle 10 aborts; reset wins over a simultaneous start.
    launch("mul_abort", 2'b01, 16'd300, 16'd7, 6'd0, 16'h0834, 1'b0, 33);
    repeat (9) step();
    check("abort_pre_busy", busy, 1'b1);
    reset_n = 1'b0; start = 1'b1; op = 2'b00;
    step();
    void'(sb.pop_front());
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_zr", zr, 1'b1);
    check("abort_alu_ctrl", alu_ctrl, 6'b101010);
    step();
    check("rst_priority_busy", busy, 1'b0);
    reset_n = 1'b1; start = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      step();
      saw_done |= done;
    end
    check("abort_no_late_done", saw_done, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
